// File: rtl/wb_uart_pkg.sv
// Shared constants and state types for the Wishbone UART.
package wb_uart_pkg;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegClear  = 2'd2;

  localparam int unsigned StatRxNotEmpty = 0;
  localparam int unsigned StatTxBusy     = 1;
  localparam int unsigned StatTxFull     = 2;
  localparam int unsigned StatRxOverrun  = 3;
  localparam int unsigned StatFrameErr   = 4;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

endpackage

// File: rtl/wb_uart_fifo.sv
// Receive FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone-slave 8N1 UART: TX holding register, RX FIFO and CTS flow control.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic        i_serial_rx,
  output logic        o_serial_tx,
  output logic        on_serial_cts,
  output logic        on_serial_dsr
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW   = $clog2(RX_FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CW-1:0]   CtsLimit = CW'(RX_FIFO_DEPTH - 2);

  logic        wb_req, wb_wr, wb_rd, tx_load, clear_wr, fifo_pop;
  logic [1:0]  wb_idx;
  logic [31:0] rd_data;
  logic        ack_q, cts_q;
  logic [31:0] data_q;
  logic        unused_bits;

  tx_state_t      tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic           tx_full_q, tx_full_d, tx_busy;

  rx_state_t      rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_push_q, rx_push_d, frame_set;
  logic [1:0]     rx_sync_q;
  logic           rx_prev_q, rx_s;

  logic           overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic [4:0]     status;

  assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:8], i_wb_sel[3:1]};

  assign wb_req   = i_wb_cyc & i_wb_stb;
  assign wb_wr    = wb_req & i_wb_we;
  assign wb_rd    = wb_req & ~i_wb_we;
  assign wb_idx   = i_wb_addr[3:2];
  assign tx_load  = wb_wr & (wb_idx == RegData) & i_wb_sel[0] & ~tx_full_q;
  assign clear_wr = wb_wr & (wb_idx == RegClear);
  assign fifo_pop = wb_rd & (wb_idx == RegData) & ~fifo_empty;
  assign tx_busy  = (tx_state_q != TxIdle);
  assign status   = {frame_err_q, overrun_q, tx_full_q, tx_busy, ~fifo_empty};
  assign rx_s     = rx_sync_q[1];

  assign o_wb_stall    = 1'b0;
  assign o_wb_ack      = ack_q;
  assign o_wb_data     = data_q;
  assign on_serial_cts = cts_q;
  assign on_serial_dsr = ~i_rst;

  wb_uart_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_push_q),
    .i_data  (rx_shift_q),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    rd_data = '0;
    if (wb_rd) begin
      case (wb_idx)
        RegData:   rd_data = {24'b0, (fifo_empty ? 8'h00 : fifo_rdata)};
        RegStatus: rd_data = {27'b0, status};
        default:   rd_data = '0;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    o_serial_tx = 1'b1;
    if (tx_load) begin
      tx_hold_d = i_wb_data[7:0];
      tx_full_d = 1'b1;
    end
    tx_cnt_d = (tx_cnt_q == CntLast) ? '0 : tx_cnt_q + CntOne;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (tx_full_q) begin
          tx_shift_d = tx_hold_q;
          tx_full_d  = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        o_serial_tx = 1'b0;
        if (tx_cnt_q == CntLast) begin
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        o_serial_tx = tx_shift_q[0];
        if (tx_cnt_q == CntLast) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntLast) tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_cnt_q == CntLast) ? '0 : rx_cnt_q + CntOne;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_d  = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        // The detecting clock counts as the first clock of the start bit.
        rx_cnt_d = CntOne;
        if (rx_prev_q && !rx_s) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_state_d = RxIdle;
          rx_push_d  = rx_s;
          frame_set  = ~rx_s;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (clear_wr && i_wb_data[StatRxOverrun]) overrun_d   = 1'b0;
    if (clear_wr && i_wb_data[StatFrameErr])  frame_err_d = 1'b0;
    if (rx_push_q && fifo_full && !fifo_pop)  overrun_d   = 1'b1;
    if (frame_set)                            frame_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_q       <= 1'b0;
      data_q      <= '0;
      cts_q       <= 1'b1;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_push_q   <= 1'b0;
      rx_sync_q   <= 2'b11;
      rx_prev_q   <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ack_q       <= wb_req;
      data_q      <= rd_data;
      cts_q       <= (fifo_count > CtsLimit);
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_push_q   <= rx_push_d;
      rx_sync_q   <= {rx_sync_q[0], i_serial_rx};
      rx_prev_q   <= rx_s;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart with 8 clocks per bit and a 4-entry RX FIFO.
module tb_wb_uart;
  localparam logic [1:0] IdxData = 2'd0, IdxStatus = 2'd1, IdxClear = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_addr = '0, wb_wdata = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_stall, wb_ack;
  logic [31:0] wb_rdata;
  logic        serial_rx = 1'b1;
  logic        serial_tx, serial_cts_n, serial_dsr_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_uart #(
    .CLKS_PER_BIT  (8),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_wb_cyc      (wb_cyc),
    .i_wb_stb      (wb_stb),
    .i_wb_we       (wb_we),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_wdata),
    .i_wb_sel      (wb_sel),
    .o_wb_stall    (wb_stall),
    .o_wb_ack      (wb_ack),
    .o_wb_data     (wb_rdata),
    .i_serial_rx   (serial_rx),
    .o_serial_tx   (serial_tx),
    .on_serial_cts (serial_cts_n),
    .on_serial_dsr (serial_dsr_n)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe; returns in the ack cycle with what the bus showed there.
  task automatic wb(input logic we, input logic [1:0] idx, input logic [31:0] d,
                    output logic ack, output logic [31:0] q);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = {28'h0, idx, 2'b00}; wb_wdata = d; wb_sel = 4'h1;
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_wdata = '0; wb_sel = '0;
    ack = wb_ack;
    q = wb_rdata;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      tick(8);
    end
    serial_rx = stop;
    tick(8);
    serial_rx = 1'b1;
  endtask

  // Called at the middle of a start bit; returns at the middle of the stop bit.
  task automatic sample_frame(output logic [9:0] f);
    f[0] = serial_tx;
    for (int i = 1; i < 10; i++) begin
      tick(8);
      f[i] = serial_tx;
    end
  endtask

  task automatic test_reset();
    logic ack; logic [31:0] q;
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if ({serial_tx, wb_ack, wb_stall, serial_cts_n, serial_dsr_n} !== 5'b10011 || wb_rdata !== 0)
      begin errors++; $display("FAIL reset_outputs: tx/ack/stall/cts/dsr=%b data=%h want 10011 0",
        {serial_tx, wb_ack, wb_stall, serial_cts_n, serial_dsr_n}, wb_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (serial_dsr_n !== 1'b0) begin errors++; $display("FAIL reset_dsr: got %b want 0", serial_dsr_n); end
    tick();
    checks++;
    if (serial_cts_n !== 1'b0) begin errors++; $display("FAIL reset_cts: got %b want 0", serial_cts_n); end
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (ack !== 1'b1 || q !== 32'h0) begin errors++;
      $display("FAIL reset_status: ack=%b data=%h want 1 00000000", ack, q); end
    wb(1'b0, 2'd3, 32'h0, ack, q);
    checks++;
    if (ack !== 1'b1 || q !== 32'h0) begin errors++;
      $display("FAIL reserved_read: ack=%b data=%h want 1 00000000", ack, q); end
  endtask

  task automatic test_tx();
    logic ack; logic [31:0] q; logic [9:0] f;
    wb(1'b1, IdxData, 32'hA5, ack, q);
    checks++;
    if (ack !== 1'b1 || serial_tx !== 1'b1) begin errors++;
      $display("FAIL tx_c1: ack=%b tx=%b want 1 1", ack, serial_tx); end
    tick();
    checks++;
    if (serial_tx !== 1'b0) begin errors++; $display("FAIL tx_start_latency: tx=%b want 0", serial_tx); end
    tick(4);
    sample_frame(f);
    checks++;
    if (f !== 10'b11_0100_1010) begin errors++; $display("FAIL tx_frame_a5: got %b want 1101001010", f); end
    tick(3);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = {28'h0, IdxStatus, 2'b00};
    tick();
    checks++;
    if (wb_ack !== 1'b1 || wb_rdata !== 32'h2) begin errors++;
      $display("FAIL tx_busy_last: ack=%b data=%h want 1 00000002", wb_ack, wb_rdata); end
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    checks++;
    if (wb_ack !== 1'b1 || wb_rdata !== 32'h0) begin errors++;
      $display("FAIL tx_idle_after80: ack=%b data=%h want 1 00000000", wb_ack, wb_rdata); end
    tick();
    checks++;
    if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin errors++;
      $display("FAIL ack_single: ack=%b data=%h want 0 00000000", wb_ack, wb_rdata); end
  endtask

  task automatic test_rx();
    logic ack; logic [31:0] q;
    send_byte(8'h3C, 1'b1);
    tick(3);
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h1) begin errors++; $display("FAIL rx_status_ne: got %h want 00000001", q); end
    tick();
    checks++;
    if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin errors++;
      $display("FAIL data_idle_zero: ack=%b data=%h want 0 00000000", wb_ack, wb_rdata); end
    wb(1'b0, IdxData, 32'h0, ack, q);
    checks++;
    if (q !== 32'h3C) begin errors++; $display("FAIL rx_data_3c: got %h want 0000003c", q); end
    wb(1'b0, IdxData, 32'h0, ack, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL rx_pop_empty: got %h want 00000000", q); end
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL rx_status_empty: got %h want 00000000", q); end
  endtask

  task automatic test_flow();
    logic ack; logic [31:0] q;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h41 + 8'(i), 1'b1);
      tick(3);
      if (i == 1) begin
        checks++;
        if (serial_cts_n !== 1'b0) begin errors++; $display("FAIL cts_two: got %b want 0", serial_cts_n); end
      end
      if (i == 2) begin
        checks++;
        if (serial_cts_n !== 1'b1) begin errors++; $display("FAIL cts_three: got %b want 1", serial_cts_n); end
      end
    end
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h9) begin errors++; $display("FAIL overrun_status: got %h want 00000009", q); end
    for (int i = 0; i < 4; i++) begin
      wb(1'b0, IdxData, 32'h0, ack, q);
      checks++;
      if (q !== 32'h41 + i) begin errors++;
        $display("FAIL fifo_order%0d: got %h want %h", i, q, 32'h41 + i); end
    end
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h8) begin errors++; $display("FAIL overrun_sticky: got %h want 00000008", q); end
    wb(1'b1, IdxClear, 32'h8, ack, q);
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL overrun_clear: got %h want 00000000", q); end
    tick();
    checks++;
    if (serial_cts_n !== 1'b0) begin errors++; $display("FAIL cts_drained: got %b want 0", serial_cts_n); end
  endtask

  task automatic test_frame();
    logic ack; logic [31:0] q;
    send_byte(8'h55, 1'b0);
    tick(3);
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h10) begin errors++; $display("FAIL frame_err: got %h want 00000010", q); end
    wb(1'b1, IdxClear, 32'h10, ack, q);
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL frame_clear: got %h want 00000000", q); end
    serial_rx = 1'b0;
    tick(3);
    serial_rx = 1'b1;
    tick(100);
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL glitch: got %h want 00000000", q); end
  endtask

  task automatic test_back_to_back();
    logic ack; logic [31:0] q; logic [9:0] f; int lows;
    wb(1'b1, IdxData, 32'h11, ack, q);
    tick();
    checks++;
    if (serial_tx !== 1'b0) begin errors++; $display("FAIL b2b_start: tx=%b want 0", serial_tx); end
    wb(1'b1, IdxData, 32'h22, ack, q);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack22: got %b want 1", ack); end
    wb(1'b1, IdxData, 32'h33, ack, q);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack33: got %b want 1", ack); end
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (q !== 32'h6) begin errors++; $display("FAIL b2b_status: got %h want 00000006", q); end
    tick();
    sample_frame(f);
    checks++;
    if (f !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL b2b_frame11: got %b want %b", f,
      {1'b1, 8'h11, 1'b0}); end
    tick(9);
    sample_frame(f);
    checks++;
    if (f !== {1'b1, 8'h22, 1'b0}) begin errors++; $display("FAIL b2b_frame22: got %b want %b", f,
      {1'b1, 8'h22, 1'b0}); end
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (serial_tx === 1'b0) lows++;
    end
    checks++;
    if (lows !== 0) begin errors++; $display("FAIL b2b_no33: low clocks=%0d want 0", lows); end
  endtask

  task automatic test_reset_mid();
    logic ack; logic [31:0] q;
    wb(1'b1, IdxData, 32'hA5, ack, q);
    tick(43);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = {28'h0, IdxStatus, 2'b00};
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    checks++;
    if (serial_tx !== 1'b0 || wb_ack !== 1'b1) begin errors++;
      $display("FAIL mid_bit4: tx=%b ack=%b want 0 1", serial_tx, wb_ack); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({serial_tx, wb_ack, serial_cts_n, serial_dsr_n} !== 4'b1011 || wb_rdata !== 0) begin errors++;
      $display("FAIL mid_reset: tx/ack/cts/dsr=%b data=%h want 1011 0",
        {serial_tx, wb_ack, serial_cts_n, serial_dsr_n}, wb_rdata); end
    tick(2);
    rst_n = 1'b1;
    #1;
    checks++;
    if (serial_dsr_n !== 1'b0) begin errors++; $display("FAIL mid_dsr: got %b want 0", serial_dsr_n); end
    tick();
    wb(1'b0, IdxStatus, 32'h0, ack, q);
    checks++;
    if (ack !== 1'b1 || q !== 32'h0 || serial_tx !== 1'b1) begin errors++;
      $display("FAIL mid_status: ack=%b data=%h tx=%b want 1 00000000 1", ack, q, serial_tx); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_flow();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_uart.md
# wb_uart

Wishbone-slave UART peripheral for the picorv32 SoC, attached to the arbiter's peripheral port alongside the MM register block. It drives the board serial pins `i_serial_rx`, `o_serial_tx`, `on_serial_cts` and `on_serial_dsr`. The core software (and the bootloader ROM program) uses it to exchange bytes with a host: 8N1 framing, one-byte TX holding register, RX FIFO with hardware flow control.

## Interface
- `CLKS_PER_BIT`, 434, system clocks per serial bit (50 MHz / 115200); minimum 4.
- `RX_FIFO_DEPTH`, 16, RX FIFO entries; power of two, at least 2.
- `i_clk`  in  1  system clock (`s_sys_clk`).
- `i_rst`  in  1  reset; asynchronous, active-low (driven by PLL `locked`).
- `i_wb_cyc`  in  1  Wishbone cycle.
- `i_wb_stb`  in  1  Wishbone strobe.
- `i_wb_we`  in  1  write enable.
- `i_wb_addr`  in  32  byte address; only bits [3:2] are decoded.
- `i_wb_data`  in  32  write data.
- `i_wb_sel`  in  4  byte lane select.
- `o_wb_stall`  out  1  stall; constant 0.
- `o_wb_ack`  out  1  acknowledge.
- `o_wb_data`  out  32  read data.
- `i_serial_rx`  in  1  serial input; asynchronous to `i_clk`.
- `o_serial_tx`  out  1  serial output; idles high.
- `on_serial_cts`  out  1  clear-to-send, active-low.
- `on_serial_dsr`  out  1  data-set-ready, active-low.

## Operation
- Register map, selected by `i_wb_addr[3:2]`:
  - 0, DATA. A write with `i_wb_sel[0]`=1 loads `i_wb_data[7:0]` into the TX holding register. A read returns `{24'b0, rx_byte}` and pops the RX FIFO.
  - 1, STATUS (read-only). Bit0 rx_not_empty, bit1 tx_busy, bit2 tx_full, bit3 rx_overrun, bit4 frame_err.
  - 2, CLEAR. A write clears the bits of {frame_err, overrun} that have 1 in `i_wb_data[4:3]`.
  - 3, reserved. Reads return 0; writes are ignored.
- Writes to STATUS or reserved: acked, no effect.
- TX path:
  - Holding register with a valid flag (tx_full).
  - Transmit FSM: TX_IDLE → TX_START → TX_DATA (8 bits, LSB first) → TX_STOP → TX_IDLE. Each state lasts CLKS_PER_BIT clocks.
  - In TX_IDLE with holding valid: the FSM moves the byte to the shifter, clears holding and enters TX_START on the next clock.
  - DATA write while tx_full=1: byte dropped, still acked.
  - tx_busy is 1 whenever the FSM is not in TX_IDLE.
- RX path:
  - `i_serial_rx` passes through a 2-FF synchronizer.
  - Receive FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: a synchronized 1→0 transition enters RX_START.
  - RX_START: samples at CLKS_PER_BIT/2. If the line is high, returns to RX_IDLE with no error (glitch).
  - RX_DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - RX_STOP: sample must be 1. Otherwise set frame_err and discard the byte.
  - Valid byte: pushed to the FIFO in the clock after the stop sample.
- FIFO boundaries:
  - Push while full: byte dropped, rx_overrun set (sticky).
  - Pop while empty: read returns 0x00000000, no pointer change.
  - Simultaneous pop and push on a full FIFO: both succeed, no overrun.
  - Pointers wrap modulo RX_FIFO_DEPTH, with an extra bit to distinguish full from empty.
- Flow control:
  - `on_serial_cts` = 0 while free entries ≥ 2, otherwise 1. It is registered.
  - `on_serial_dsr` = 0 in every clock after reset is released.

## Timing
- Wishbone:
  - `o_wb_ack` pulses for one clock, one clock after each clock in which `i_wb_cyc & i_wb_stb` is high. Back-to-back strobes get back-to-back acks.
  - `o_wb_data` is valid in the ack cycle and is 0 in all other cycles.
  - The DATA-read pop takes effect in the ack cycle.
  - A STATUS read returns the values from the strobe cycle.
- TX latency: `o_serial_tx` falls 2 clocks after the write strobe cycle (1 clock load, 1 clock FSM). A frame lasts 10·CLKS_PER_BIT clocks.
- RX latency: rx_not_empty rises 2 + 9.5·CLKS_PER_BIT clocks (±1) after the start-bit falling edge at the pin.
- Reset (asynchronous; active from assertion until release):

  | Signal / state | Value in reset |
  |---|---|
  | `o_serial_tx` | 1 |
  | `o_wb_ack` | 0 |
  | `o_wb_data` | 0 |
  | `o_wb_stall` | 0 |
  | `on_serial_cts` | 1 |
  | `on_serial_dsr` | 1 |
  | FSMs | IDLE |
  | FIFO | emptied |
  | Sticky bits | cleared |
  | Synchronizer | all 1 |

- Reset mid-frame aborts the frame immediately. The TX line returns high at once.

## Structure
- Package `wb_uart_pkg`:
  - Register index constants: DATA=0, STATUS=1, CLEAR=2.
  - STATUS bit positions.
  - `tx_state_t` and `rx_state_t` enums.
- Sub-module `wb_uart_fifo`:
  - Parameterized by depth and width (8).
  - push/pop/full/empty/count ports.
  - Same `i_clk`/`i_rst` convention.
- Top level: Wishbone decode, TX FSM, RX FSM, synchronizer.

## Test plan
All scenarios use CLKS_PER_BIT=8 and RX_FIFO_DEPTH=4.
1. Write 0x000000A5 to DATA → `o_serial_tx` low 2 clocks later. Frame is 0,1,0,1,0,0,1,0,1,1 with 8 clocks per bit. tx_busy=1 for 80 clocks.
2. Drive 0x3C on rx → STATUS bit0=1. DATA read returns 0x0000003C. A second read returns 0 and STATUS bit0=0.
3. Send 5 bytes without popping → `on_serial_cts`=1 after the 3rd byte. After the 5th: STATUS bit3=1 and the FIFO holds the first 4 bytes. Write 0x08 to CLEAR → bit3=0.
4. Rx frame with stop bit 0 → STATUS bit4=1, FIFO stays empty. A 3-clock low glitch on rx → no byte, no error.
5. Two DATA writes (0x11, 0x22) then a third (0x33) while tx_full=1 → line carries 0x11 then 0x22; 0x33 is never sent. Every write acked.
6. Assert `i_rst` during TX bit 4 → `o_serial_tx`=1 and `o_wb_ack`=0 immediately. After release: STATUS=0 and `on_serial_dsr`=0 from the first clock on.
